// File: rtl/rng_vn_packer.sv
// TRNG front end: von Neumann debiaser, repetition-count health test
// and 32-bit word packer with a one-cycle ready strobe.
module rng_vn_packer #(
    parameter int WORD_W    = 32,
    parameter int REP_LIMIT = 16,
    parameter int CNT_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              raw_bit,
    input  logic              raw_valid,
    output logic [WORD_W-1:0] rnd_out,
    output logic              ready,
    output logic              health_fail,
    output logic [7:0]        fail_count
);

    localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REP_LIMIT);
    localparam logic [CNT_W-1:0] REP_PRE  = CNT_W'(REP_LIMIT - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    logic [CNT_W-1:0]  rep_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic              last_raw;
    logic              pending;
    logic              first_bit;
    logic              blocked;
    logic [WORD_W-1:0] shift;

    logic              acc;
    logic              same;
    logic              trip;
    logic              discard;
    logic              use_bit;
    logic              emit;
    logic              done;
    logic [WORD_W-1:0] word_nxt;

    always_comb begin
        acc      = en & raw_valid;
        same     = (rep_cnt != '0) && (raw_bit == last_raw);
        trip     = acc && same && (rep_cnt == REP_PRE);
        // repeats after a trip are dropped until the stream changes value
        discard  = blocked && same;
        use_bit  = acc && !trip && !discard;
        emit     = use_bit && pending && (first_bit != raw_bit);
        done     = emit && (bit_cnt == LAST_BIT);
        word_nxt = {shift[WORD_W-2:0], first_bit};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rnd_out     <= '0;
            ready       <= 1'b0;
            health_fail <= 1'b0;
            fail_count  <= '0;
            rep_cnt     <= '0;
            last_raw    <= 1'b0;
            pending     <= 1'b0;
            first_bit   <= 1'b0;
            bit_cnt     <= '0;
            shift       <= '0;
            blocked     <= 1'b0;
        end else begin
            ready       <= done;
            health_fail <= trip;
            if (acc) begin
                last_raw <= raw_bit;
                if (!same) begin
                    rep_cnt <= CNT_W'(1);
                    blocked <= 1'b0;
                end else if (rep_cnt != REP_MAX) begin
                    rep_cnt <= rep_cnt + CNT_W'(1);
                end
            end
            if (trip) begin
                blocked <= 1'b1;
                pending <= 1'b0;
                bit_cnt <= '0;
                if (fail_count != 8'hFF) begin
                    fail_count <= fail_count + 8'd1;
                end
            end else if (use_bit) begin
                if (!pending) begin
                    first_bit <= raw_bit;
                    pending   <= 1'b1;
                end else begin
                    pending <= 1'b0;
                    if (emit) begin
                        shift <= word_nxt;
                        if (done) begin
                            rnd_out <= word_nxt;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rng_vn_packer.sv
// Bench for rng_vn_packer: randomized pair streams checked against a
// queue-based model of debiasing, run-length health test and packing.
module tb_rng_vn_packer;

    localparam int REP = 16;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        raw_bit;
    logic        raw_valid;
    logic [31:0] rnd_out;
    logic        ready;
    logic        health_fail;
    logic [7:0]  fail_count;

    rng_vn_packer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .raw_bit     (raw_bit),
        .raw_valid   (raw_valid),
        .rnd_out     (rnd_out),
        .ready       (ready),
        .health_fail (health_fail),
        .fail_count  (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model state
    int          m_run;
    bit          m_last;
    bit          m_pair[$];
    bit          m_word[$];
    logic [7:0]  m_fc;
    logic [31:0] m_rnd;
    logic        exp_ready;
    logic        exp_hf;

    function automatic void model_reset();
        m_run = 0;
        m_last = 1'b0;
        m_pair.delete();
        m_word.delete();
        m_fc = 8'd0;
        m_rnd = 32'd0;
        exp_ready = 1'b0;
        exp_hf = 1'b0;
    endfunction

    // run length is tracked unbounded; bits beyond the limit are dropped
    function automatic void model_accept(input bit b);
        exp_ready = 1'b0;
        exp_hf = 1'b0;
        if (m_run > 0 && b == m_last) m_run++;
        else m_run = 1;
        m_last = b;
        if (m_run == REP) begin
            exp_hf = 1'b1;
            if (m_fc != 8'd255) m_fc++;
            m_pair.delete();
            m_word.delete();
        end else if (m_run < REP) begin
            m_pair.push_back(b);
            if (m_pair.size() == 2) begin
                if (m_pair[0] != m_pair[1]) m_word.push_back(m_pair[0]);
                m_pair.delete();
            end
            if (m_word.size() == 32) begin
                for (int i = 0; i < 32; i++) m_rnd = {m_rnd[30:0], m_word[i]};
                m_word.delete();
                exp_ready = 1'b1;
            end
        end
    endfunction

    task automatic step(input bit e, input bit v, input bit b);
        @(negedge clk);
        en = e;
        raw_valid = v;
        raw_bit = b;
        @(posedge clk);
        #1;
        if (e && v) model_accept(b);
        else begin
            exp_ready = 1'b0;
            exp_hf = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
        raw_valid = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        n_vec++;
        if (rnd_out !== 32'd0 || ready !== 1'b0 ||
            health_fail !== 1'b0 || fail_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset: rnd=%h rdy=%b hf=%b fc=%0d expected 0 0 0 0",
                     rnd_out, ready, health_fail, fail_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_ones_word();
        int nr = 0;
        for (int i = 0; i < 64; i++) begin
            step(1, 1, (i % 2) == 0);
            nr += int'(ready);
            n_vec++;
            if (ready !== exp_ready || health_fail !== exp_hf ||
                fail_count !== m_fc || rnd_out !== m_rnd) begin
                n_err++;
                $display("FAIL ones bit %0d: rdy=%b hf=%b fc=%0d rnd=%h want %b %b %0d %h",
                         i, ready, health_fail, fail_count, rnd_out,
                         exp_ready, exp_hf, m_fc, m_rnd);
            end
        end
        n_vec++;
        if (rnd_out !== 32'hFFFF_FFFF || nr != 1) begin
            n_err++;
            $display("FAIL ones word: rnd=%h pulses=%0d want ffffffff 1", rnd_out, nr);
        end
    endtask

    task automatic test_pattern();
        logic [31:0] w = 32'hA5A5_A5A5;
        bit s[$];
        int nr = 0;
        bit b;
        for (int i = 31; i >= 0; i--) begin
            if ($urandom_range(0, 2) == 0) begin
                b = 1'($urandom);
                s.push_back(b);
                s.push_back(b);
            end
            s.push_back(w[i]);
            s.push_back(!w[i]);
        end
        foreach (s[k]) begin
            step(1, 1, s[k]);
            nr += int'(ready);
            n_vec++;
            if (ready !== exp_ready || health_fail !== exp_hf ||
                fail_count !== m_fc || rnd_out !== m_rnd) begin
                n_err++;
                $display("FAIL pattern bit %0d: rdy=%b hf=%b fc=%0d rnd=%h want %b %b %0d %h",
                         k, ready, health_fail, fail_count, rnd_out,
                         exp_ready, exp_hf, m_fc, m_rnd);
            end
        end
        n_vec++;
        if (rnd_out !== 32'hA5A5_A5A5 || nr != 1) begin
            n_err++;
            $display("FAIL pattern word: rnd=%h pulses=%0d want a5a5a5a5 1", rnd_out, nr);
        end
    endtask

    task automatic test_health();
        bit s[$];
        int nr = 0;
        int nh = 0;
        for (int i = 0; i < 10; i++) begin
            s.push_back(1'b1);
            s.push_back(1'b0);
        end
        for (int i = 0; i < 20; i++) s.push_back(1'b1);
        s.push_back(1'b0);
        s.push_back(1'b1);
        for (int i = 0; i < 31; i++) begin
            s.push_back(1'b0);
            s.push_back(1'b1);
        end
        foreach (s[k]) begin
            step(1, 1, s[k]);
            nr += int'(ready);
            nh += int'(health_fail);
            n_vec++;
            if (ready !== exp_ready || health_fail !== exp_hf ||
                fail_count !== m_fc || rnd_out !== m_rnd) begin
                n_err++;
                $display("FAIL health bit %0d: rdy=%b hf=%b fc=%0d rnd=%h want %b %b %0d %h",
                         k, ready, health_fail, fail_count, rnd_out,
                         exp_ready, exp_hf, m_fc, m_rnd);
            end
            if (k == 35) begin
                n_vec++;
                if (health_fail !== 1'b1) begin
                    n_err++;
                    $display("FAIL health timing: hf=%b want 1 after 16th one", health_fail);
                end
            end
        end
        n_vec++;
        if (rnd_out !== 32'd0 || fail_count !== 8'd1 || nr != 1 || nh != 1) begin
            n_err++;
            $display("FAIL health summary: rnd=%h fc=%0d rdy=%0d hf=%0d want 0 1 1 1",
                     rnd_out, fail_count, nr, nh);
        end
    endtask

    task automatic test_gap();
        logic [31:0] w = $urandom;
        int nr = 0;
        bit b;
        for (int i = 31; i >= 0; i--) begin
            for (int h = 0; h < 2; h++) begin
                b = (h == 0) ? w[i] : !w[i];
                while ($urandom_range(0, 2) == 0) begin
                    step(1, 0, 1'($urandom));
                    nr += int'(ready);
                end
                if (i == 21 && h == 1) begin
                    for (int g = 0; g < 50; g++) begin
                        step(0, 1'($urandom), 1'($urandom));
                        n_vec++;
                        if (ready !== 1'b0 || health_fail !== 1'b0) begin
                            n_err++;
                            $display("FAIL gap en-low %0d: rdy=%b hf=%b want 0 0",
                                     g, ready, health_fail);
                        end
                    end
                end
                step(1, 1, b);
                nr += int'(ready);
                n_vec++;
                if (ready !== exp_ready || health_fail !== exp_hf ||
                    fail_count !== m_fc || rnd_out !== m_rnd) begin
                    n_err++;
                    $display("FAIL gap bit %0d.%0d: rdy=%b hf=%b fc=%0d rnd=%h want %b %b %0d %h",
                             i, h, ready, health_fail, fail_count, rnd_out,
                             exp_ready, exp_hf, m_fc, m_rnd);
                end
            end
        end
        n_vec++;
        if (rnd_out !== w || nr != 1) begin
            n_err++;
            $display("FAIL gap word: rnd=%h pulses=%0d want %h 1", rnd_out, nr, w);
        end
    endtask

    task automatic test_saturate();
        int nh = 0;
        do_reset();
        for (int r = 0; r < 300; r++) begin
            for (int i = 0; i < 17; i++) begin
                step(1, 1, i < 16);
                nh += int'(health_fail);
                n_vec++;
                if (ready !== exp_ready || health_fail !== exp_hf ||
                    fail_count !== m_fc) begin
                    n_err++;
                    $display("FAIL sat run %0d bit %0d: rdy=%b hf=%b fc=%0d want %b %b %0d",
                             r, i, ready, health_fail, fail_count,
                             exp_ready, exp_hf, m_fc);
                end
            end
        end
        n_vec++;
        if (fail_count !== 8'd255 || nh != 300) begin
            n_err++;
            $display("FAIL sat summary: fc=%0d trips=%0d want 255 300", fail_count, nh);
        end
    endtask

    task automatic test_reset_mid();
        int nr = 0;
        for (int i = 0; i < 104; i++) begin
            step(1, 1, (i % 2) == 0);
            n_vec++;
            if (ready !== exp_ready || rnd_out !== m_rnd || fail_count !== m_fc) begin
                n_err++;
                $display("FAIL mid pre bit %0d: rdy=%b rnd=%h fc=%0d want %b %h %0d",
                         i, ready, rnd_out, fail_count, exp_ready, m_rnd, m_fc);
            end
        end
        do_reset();
        for (int i = 0; i < 64; i++) begin
            step(1, 1, (i % 2) == 0);
            nr += int'(ready);
            n_vec++;
            if (ready !== (i == 63) || rnd_out !== m_rnd || ready !== exp_ready) begin
                n_err++;
                $display("FAIL mid post bit %0d: rdy=%b rnd=%h want %b %h",
                         i, ready, rnd_out, (i == 63), m_rnd);
            end
        end
        n_vec++;
        if (rnd_out !== 32'hFFFF_FFFF || nr != 1) begin
            n_err++;
            $display("FAIL mid word: rnd=%h pulses=%0d want ffffffff 1", rnd_out, nr);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        raw_bit = 1'b0;
        raw_valid = 1'b0;
        model_reset();
        test_reset();
        test_ones_word();
        test_pattern();
        test_health();
        test_gap();
        test_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
